digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Parametrised digit-serial adder/subtractor: successor to the 4-bit combinational full adder, generalised to WIDTH bits. Each cycle it processes one DIGIT-bit slice, LSB first, through a registered carry chain, trading latency for a small adder. It uses a valid/ready handshake on both input and output so it can sit between pipeline stages in the arithmetic datapath.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- c_in  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  0: a+b+c_in; 1: a−b−c_in.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a into the A shift register.
  - latch b, or ~b when sub=1, into the B shift register.
  - load the carry register with c_in (add) or !c_in (subtract), so subtract computes a+~b+!c_in.
  - clear the digit counter; go to RUN.
- RUN, one digit per cycle:
  - add the low DIGIT bits of A and B plus the carry register.
  - shift the DIGIT-bit result into the top of the sum register; shift A and B right by DIGIT.
  - update the carry register.
  - on the last digit (counter == NDIG−1), also capture c_out and ovf, then go to DONE.
- DONE: out_valid=1; sum, c_out and ovf held stable. On out_ready go to IDLE.
- sum, c_out and ovf keep their last value after the output handshake until the next operation completes.
- Inputs are ignored outside IDLE; in_valid during RUN or DONE has no effect.
- Mode and c_in are sampled only at the input handshake.
- Width rules:
  - Internal arithmetic is DIGIT+1 bits per slice.
  - The carry into the MSB comes from the top bit of the last slice.
  - Digit counter width is max(1, $clog2(NDIG)).
- NDIG=1 is legal: RUN lasts exactly one cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, c_out=0, ovf=0.
  - carry, counter and shift registers are 0.
- Reset mid-RUN or mid-DONE aborts the operation, discards its result and applies the reset values immediately.
- Latency: input handshake at edge 0 → out_valid high after edge NDIG.
- Throughput:
  - With out_ready held high, DONE lasts one cycle and in_ready returns after edge NDIG+1.
  - Minimum period is NDIG+2 cycles per operation.
- in_ready and out_valid are decoded directly from the state register (glitch-free, no combinational path from inputs).
- out_ready low holds DONE indefinitely; out_valid never drops without a handshake.

## Structure
- Package adder_pkg:
  - state enum (IDLE, RUN, DONE).
  - the NDIG and counter-width computation as functions/localparams.
  - a parameter-legality check (WIDTH % DIGIT == 0) that fails elaboration.
- Sub-module adder_digit (combinational, parameter DIGIT):
  - inputs: x, y, cin.
  - outputs: s, cout, and cmsb (carry into the top bit).
  - instantiated once.
- The FSM, counter and shift registers live in digit_serial_adder.

## Test plan
Default WIDTH=16, DIGIT=4.
- Add basic: a=0x1234, b=0x4321, c_in=0, sub=0 → sum=0x5555, c_out=0, ovf=0; out_valid exactly 4 cycles after accept.
- Carry wrap: a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, ovf=1.
- Subtract:
  - a=0x0005, b=0x0007, c_in=0, sub=1 → sum=0xFFFE, c_out=0 (borrow).
  - a=0x0010, b=0x0001, c_in=1, sub=1 → sum=0x000E, c_out=1.
- Backpressure: hold out_ready=0 for 5 cycles and pulse in_valid with new operands → sum, c_out and ovf stay stable, in_ready=0, new operands are ignored. Then release out_ready → one handshake and return to IDLE.
- Reset mid-RUN: assert rst_n=0 two cycles after accept → out_valid=0, in_ready=1 and sum=0 immediately. The next operation (0x00FF+0x0001) gives 0x0100.
- Random compare against a reference model: 1000 random operations with random sub, c_in and out_ready stalls, repeated for DIGIT ∈ {1, 4, 16}.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and parameter helpers for the digit-serial adder.
// Holds the FSM state encoding and digit-count arithmetic.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calc_cnt_w(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

    function automatic bit params_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && (width % digit == 0);
    endfunction

endpackage

// File: rtl/adder_digit.sv
// One DIGIT-bit slice of the adder, purely combinational.
// Also exposes the carry into its top bit for overflow detection.
module adder_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] full;

    assign full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    assign s    = full[DIGIT-1:0];
    assign cout = full[DIGIT];
    // top sum bit is x^y^carry_in, so the carry in falls out by xor
    assign cmsb = x[DIGIT-1] ^ y[DIGIT-1] ^ s[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor, LSB digit first, with a registered
// carry and valid/ready handshakes on both sides.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int CW   = calc_cnt_w(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             dig_cmsb;
    logic [WIDTH-1:0] acc_shift;

    adder_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .x   (a_q[DIGIT-1:0]),
        .y   (b_q[DIGIT-1:0]),
        .cin (carry_q),
        .s   (dig_s),
        .cout(dig_cout),
        .cmsb(dig_cmsb)
    );

    // new digit enters at the top; after NDIG shifts the word is aligned
    assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

    // next-state: load operands, step one digit per cycle, hold result
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = c_in ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_shift;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = acc_shift;
                    c_out_d = dig_cout;
                    ovf_d   = dig_cout ^ dig_cmsb;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench: three DUTs (DIGIT 1, 4, 16), directed
// scenarios on DIGIT=4 and randomized runs against a reference model.
module tb_digit_serial_adder;

    logic clk;
    logic rst_n;

    logic [2:0]       in_valid_w;
    logic [2:0]       in_ready_w;
    logic [2:0][15:0] a_w;
    logic [2:0][15:0] b_w;
    logic [2:0]       c_in_w;
    logic [2:0]       sub_w;
    logic [2:0]       out_valid_w;
    logic [2:0]       out_ready_w;
    logic [2:0][15:0] sum_w;
    logic [2:0]       c_out_w;
    logic [2:0]       ovf_w;

    int n_cmp;
    int n_bad;

    logic [15:0] exp_sum [3];
    logic        exp_co  [3];
    logic        exp_ov  [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int D = (k == 0) ? 1 : (k == 1) ? 4 : 16;
        digit_serial_adder #(
            .WIDTH(16),
            .DIGIT(D)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid_w[k]),
            .in_ready (in_ready_w[k]),
            .a        (a_w[k]),
            .b        (b_w[k]),
            .c_in     (c_in_w[k]),
            .sub      (sub_w[k]),
            .out_valid(out_valid_w[k]),
            .out_ready(out_ready_w[k]),
            .sum      (sum_w[k]),
            .c_out    (c_out_w[k]),
            .ovf      (ovf_w[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ndig_of(input int k);
        return (k == 0) ? 16 : (k == 1) ? 4 : 1;
    endfunction

    // integer-level model: returns {c_out, ovf, sum}
    function automatic logic [17:0] ref_op(input logic [15:0] av,
                                           input logic [15:0] bv,
                                           input logic ci,
                                           input logic sb);
        longint ua, ub, ur;
        int     sa, sbv, r, cv;
        logic   co, ov;
        logic [15:0] s;
        ua  = longint'(av);
        ub  = longint'(bv);
        cv  = ci ? 1 : 0;
        sa  = int'($signed(av));
        sbv = int'($signed(bv));
        if (!sb) begin
            ur = ua + ub + longint'(cv);
            co = (ur >= 65536);
            r  = sa + sbv + cv;
        end else begin
            ur = ua - ub - longint'(cv);
            co = (ur >= 0);
            r  = sa - sbv - cv;
        end
        s  = ur[15:0];
        ov = (r > 32767) || (r < -32768);
        return {co, ov, s};
    endfunction

    task automatic clear_exp();
        for (int k = 0; k < 3; k++) begin
            exp_sum[k] = '0;
            exp_co[k]  = 1'b0;
            exp_ov[k]  = 1'b0;
        end
    endtask

    // one full operation on instance k, checked against the model
    task automatic do_op(input int k, input logic [15:0] av,
                         input logic [15:0] bv, input logic ci,
                         input logic sb, input int stall,
                         input bit noise, input string tag,
                         output logic [15:0] o_sum, output logic o_co,
                         output logic o_ov);
        logic [17:0] r;
        int          lat;
        int          w;
        o_sum = 'x;
        o_co  = 1'bx;
        o_ov  = 1'bx;
        r     = ref_op(av, bv, ci, sb);
        w     = 0;
        while (in_ready_w[k] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (in_ready_w[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s in_ready timeout: got %b want 1", tag,
                     in_ready_w[k]);
            return;
        end
        a_w[k]        = av;
        b_w[k]        = bv;
        c_in_w[k]     = ci;
        sub_w[k]      = sb;
        in_valid_w[k] = 1'b1;
        @(negedge clk);
        in_valid_w[k] = 1'b0;
        lat = 0;
        while (out_valid_w[k] !== 1'b1 && lat < 40) begin
            n_cmp++;
            if (sum_w[k] !== exp_sum[k]) begin
                n_bad++;
                $display("FAIL %s hold during run: sum %h want %h", tag,
                         sum_w[k], exp_sum[k]);
            end
            if (noise) begin
                in_valid_w[k] = 1'($urandom_range(0, 1));
                a_w[k]        = 16'($urandom);
                b_w[k]        = 16'($urandom);
                c_in_w[k]     = 1'($urandom_range(0, 1));
                sub_w[k]      = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != ndig_of(k)) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat,
                     ndig_of(k));
            if (lat >= 40) begin
                in_valid_w[k] = 1'b0;
                return;
            end
        end
        exp_sum[k] = r[15:0];
        exp_ov[k]  = r[16];
        exp_co[k]  = r[17];
        o_sum      = sum_w[k];
        o_co       = c_out_w[k];
        o_ov       = ovf_w[k];
        n_cmp++;
        if ({c_out_w[k], ovf_w[k], sum_w[k]} !== r) begin
            n_bad++;
            $display("FAIL %s result: got co=%b ov=%b sum=%h want co=%b ov=%b sum=%h",
                     tag, c_out_w[k], ovf_w[k], sum_w[k], r[17], r[16],
                     r[15:0]);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid_w[k] !== 1'b1 || in_ready_w[k] !== 1'b0 ||
                {c_out_w[k], ovf_w[k], sum_w[k]} !== r) begin
                n_bad++;
                $display("FAIL %s stall hold: ov=%b ir=%b res=%h want 1 0 %h",
                         tag, out_valid_w[k], in_ready_w[k],
                         {c_out_w[k], ovf_w[k], sum_w[k]}, r);
            end
        end
        in_valid_w[k]  = 1'b0;
        out_ready_w[k] = 1'b1;
        @(negedge clk);
        out_ready_w[k] = 1'b0;
        n_cmp++;
        if (out_valid_w[k] !== 1'b0 || in_ready_w[k] !== 1'b1 ||
            sum_w[k] !== r[15:0]) begin
            n_bad++;
            $display("FAIL %s release: ov=%b ir=%b sum=%h want 0 1 %h",
                     tag, out_valid_w[k], in_ready_w[k], sum_w[k], r[15:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (in_ready_w[k] !== 1'b1 || out_valid_w[k] !== 1'b0 ||
                sum_w[k] !== 16'h0 || c_out_w[k] !== 1'b0 ||
                ovf_w[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset[%0d]: ir=%b ov=%b sum=%h co=%b of=%b want 1 0 0000 0 0",
                         k, in_ready_w[k], out_valid_w[k], sum_w[k],
                         c_out_w[k], ovf_w[k]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_exp();
        @(negedge clk);
    endtask

    task automatic test_add_basic();
        logic [15:0] s;
        logic        co, ov;
        do_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0, "add_basic",
              s, co, ov);
        n_cmp++;
        if ({co, ov, s} !== {1'b0, 1'b0, 16'h5555}) begin
            n_bad++;
            $display("FAIL add_basic const: got %b %b %h want 0 0 5555",
                     co, ov, s);
        end
    endtask

    task automatic test_carry_wrap();
        logic [15:0] s;
        logic        co, ov;
        do_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "wrap",
              s, co, ov);
        n_cmp++;
        if ({co, ov, s} !== {1'b1, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL wrap const: got %b %b %h want 1 0 0000",
                     co, ov, s);
        end
        do_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "ovf",
              s, co, ov);
        n_cmp++;
        if ({co, ov, s} !== {1'b0, 1'b1, 16'h8000}) begin
            n_bad++;
            $display("FAIL ovf const: got %b %b %h want 0 1 8000",
                     co, ov, s);
        end
    endtask

    task automatic test_subtract();
        logic [15:0] s;
        logic        co, ov;
        do_op(1, 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, "sub_borrow",
              s, co, ov);
        n_cmp++;
        if ({co, s} !== {1'b0, 16'hFFFE}) begin
            n_bad++;
            $display("FAIL sub_borrow const: got %b %h want 0 fffe", co, s);
        end
        do_op(1, 16'h0010, 16'h0001, 1'b1, 1'b1, 0, 1'b0, "sub_bin",
              s, co, ov);
        n_cmp++;
        if ({co, s} !== {1'b1, 16'h000E}) begin
            n_bad++;
            $display("FAIL sub_bin const: got %b %h want 1 000e", co, s);
        end
    endtask

    task automatic test_backpressure();
        int w;
        w = 0;
        while (in_ready_w[1] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        a_w[1]        = 16'h1111;
        b_w[1]        = 16'h2222;
        c_in_w[1]     = 1'b0;
        sub_w[1]      = 1'b0;
        in_valid_w[1] = 1'b1;
        @(negedge clk);
        in_valid_w[1] = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid_w[1] = 1'b1;
            a_w[1]        = 16'($urandom);
            b_w[1]        = 16'($urandom);
            sub_w[1]      = 1'($urandom_range(0, 1));
            c_in_w[1]     = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_cmp++;
            if (out_valid_w[1] !== 1'b1 || in_ready_w[1] !== 1'b0 ||
                sum_w[1] !== 16'h3333 || c_out_w[1] !== 1'b0 ||
                ovf_w[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL backpressure %0d: ov=%b ir=%b sum=%h co=%b of=%b want 1 0 3333 0 0",
                         i, out_valid_w[1], in_ready_w[1], sum_w[1],
                         c_out_w[1], ovf_w[1]);
            end
        end
        in_valid_w[1]  = 1'b0;
        out_ready_w[1] = 1'b1;
        @(negedge clk);
        out_ready_w[1] = 1'b0;
        n_cmp++;
        if (out_valid_w[1] !== 1'b0 || in_ready_w[1] !== 1'b1 ||
            sum_w[1] !== 16'h3333) begin
            n_bad++;
            $display("FAIL bp release: ov=%b ir=%b sum=%h want 0 1 3333",
                     out_valid_w[1], in_ready_w[1], sum_w[1]);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready_w[1] !== 1'b1 || out_valid_w[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp idle: ir=%b ov=%b want 1 0",
                     in_ready_w[1], out_valid_w[1]);
        end
        exp_sum[1] = 16'h3333;
        exp_co[1]  = 1'b0;
        exp_ov[1]  = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s;
        logic        co, ov;
        a_w[1]        = 16'hABCD;
        b_w[1]        = 16'h1357;
        c_in_w[1]     = 1'b1;
        sub_w[1]      = 1'b0;
        in_valid_w[1] = 1'b1;
        @(negedge clk);
        in_valid_w[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid_w[1] !== 1'b0 || in_ready_w[1] !== 1'b1 ||
            sum_w[1] !== 16'h0) begin
            n_bad++;
            $display("FAIL mid_run reset: ov=%b ir=%b sum=%h want 0 1 0000",
                     out_valid_w[1], in_ready_w[1], sum_w[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_exp();
        @(negedge clk);
        do_op(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "after_reset",
              s, co, ov);
        n_cmp++;
        if (s !== 16'h0100) begin
            n_bad++;
            $display("FAIL after_reset const: got %h want 0100", s);
        end
    endtask

    task automatic test_random(input int k);
        logic [15:0] s;
        logic        co, ov;
        for (int i = 0; i < 1000; i++) begin
            if (n_bad > 20) break;
            do_op(k, 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'b1, "random", s, co, ov);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        in_valid_w  = '0;
        out_ready_w = '0;
        a_w         = '0;
        b_w         = '0;
        c_in_w      = '0;
        sub_w       = '0;
        clear_exp();
        @(negedge clk);
        test_reset();
        test_add_basic();
        test_carry_wrap();
        test_subtract();
        test_backpressure();
        test_reset_mid_run();
        for (int k = 0; k < 3; k++) begin
            test_random(k);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
